// File: rtl/cajero_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | cajero_pkg : shared state encoding and transaction type codes   |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
package cajero_pkg;

    localparam int ESTADO_W = 6;

    localparam logic [ESTADO_W-1:0] S_IDLE           = 6'b000001;
    localparam logic [ESTADO_W-1:0] S_RECIBIENDO_PIN = 6'b000010;
    localparam logic [ESTADO_W-1:0] S_COMPARAR_PIN   = 6'b000100;
    localparam logic [ESTADO_W-1:0] S_ESPERA_MONTO   = 6'b001000;
    localparam logic [ESTADO_W-1:0] S_TRANSACCION    = 6'b010000;
    localparam logic [ESTADO_W-1:0] S_BLOQUEO        = 6'b100000;

    typedef enum logic [ESTADO_W-1:0] {
        ST_IDLE           = S_IDLE,
        ST_RECIBIENDO_PIN = S_RECIBIENDO_PIN,
        ST_COMPARAR_PIN   = S_COMPARAR_PIN,
        ST_ESPERA_MONTO   = S_ESPERA_MONTO,
        ST_TRANSACCION    = S_TRANSACCION,
        ST_BLOQUEO        = S_BLOQUEO
    } estado_e;

    localparam logic DEPOSITO = 1'b0;
    localparam logic RETIRO   = 1'b1;

endpackage
`default_nettype wire

// File: rtl/cajero_pin_colector.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | cajero_pin_colector : PIN digit shift register and digit count  |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module cajero_pin_colector #(
    parameter int PIN_DIGITS = 4
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic                    clear_i,
    input  logic                    digito_stb_i,
    input  logic [3:0]              digito_i,
    output logic [4*PIN_DIGITS-1:0] pin_recibido_o,
    output logic                    completo_o
);

    localparam int CNT_W = $clog2(PIN_DIGITS + 1);
    localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(PIN_DIGITS - 1);

    logic [CNT_W-1:0]        cuenta_q;
    logic [4*PIN_DIGITS-1:0] pin_q;
    logic [4*PIN_DIGITS-1:0] pin_d;

    generate
        if (PIN_DIGITS == 1) begin : g_un_digito
            assign pin_d = digito_i;
        end else begin : g_varios_digitos
            assign pin_d = {pin_q[4*PIN_DIGITS-5:0], digito_i};
        end
    endgenerate

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            cuenta_q <= '0;
            pin_q    <= '0;
        end else if (clear_i) begin
            cuenta_q <= '0;
        end else if (digito_stb_i) begin
            cuenta_q <= cuenta_q + CNT_W'(1);
            pin_q    <= pin_d;
        end
    end

    // Combinational so the final strobe can advance the FSM on its own edge.
    assign completo_o     = digito_stb_i && !clear_i && (cuenta_q == ULTIMO);
    assign pin_recibido_o = pin_q;

endmodule
`default_nettype wire

// File: rtl/cajero_param.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | cajero_param : ATM controller - PIN check, lock, deposit/withdraw|
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module cajero_param
    import cajero_pkg::*;
#(
    parameter int PIN_DIGITS   = 4,
    parameter int BAL_W        = 64,
    parameter int MONTO_W      = 32,
    parameter int MAX_INTENTOS = 3,
    parameter int TIMEOUT_CYC  = 1024
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    tarjeta_recibida,
    input  logic                    tipo_trans,
    input  logic                    digito_stb,
    input  logic [3:0]              digito,
    input  logic [4*PIN_DIGITS-1:0] pin,
    input  logic [BAL_W-1:0]        balance_inicial,
    input  logic [MONTO_W-1:0]      monto,
    input  logic                    monto_stb,
    output logic [BAL_W-1:0]        balance,
    output logic                    balance_actualizado,
    output logic                    entregar_dinero,
    output logic                    pin_incorrecto,
    output logic                    advertencia,
    output logic                    bloqueo,
    output logic                    fondos_insuficientes,
    output logic                    desborde,
    output logic                    tiempo_agotado
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC);
    localparam int INT_W = $clog2(MAX_INTENTOS + 1);
    localparam logic [TMO_W-1:0] TMO_LIMITE = TMO_W'(TIMEOUT_CYC - 2);
    localparam logic [INT_W-1:0] INT_MAX    = INT_W'(MAX_INTENTOS);
    localparam logic [INT_W-1:0] INT_AVISO  = INT_W'(MAX_INTENTOS - 1);

    estado_e             estado_q;
    logic [BAL_W-1:0]    balance_q;
    logic [MONTO_W-1:0]  monto_q;
    logic                tipo_q;
    logic [INT_W-1:0]    intentos_q;
    logic [INT_W-1:0]    intentos_d;
    logic [TMO_W-1:0]    tmo_q;
    logic                actualizado_q, entregar_q, incorrecto_q, advertencia_q;
    logic                bloqueo_q, fondos_q, desborde_q, agotado_q;

    logic [4*PIN_DIGITS-1:0] pin_recibido;
    logic                    pin_completo;
    logic                    digito_aceptado;
    logic                    colector_clear;
    logic [BAL_W:0]          suma;
    logic [BAL_W-1:0]        monto_ext;

    // Card removal outranks a strobe arriving in the same cycle.
    assign digito_aceptado = (estado_q == ST_RECIBIENDO_PIN) && tarjeta_recibida && digito_stb;
    assign colector_clear  = (estado_q != ST_RECIBIENDO_PIN);
    assign monto_ext       = BAL_W'(monto_q);
    assign suma            = {1'b0, balance_q} + (BAL_W + 1)'(monto_q);
    assign intentos_d      = intentos_q + INT_W'(1);

    cajero_pin_colector #(
        .PIN_DIGITS (PIN_DIGITS)
    ) u_colector (
        .clock_i        (clock),
        .reset_i        (reset),
        .clear_i        (colector_clear),
        .digito_stb_i   (digito_aceptado),
        .digito_i       (digito),
        .pin_recibido_o (pin_recibido),
        .completo_o     (pin_completo)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_q      <= ST_IDLE;
            balance_q     <= '0;
            monto_q       <= '0;
            tipo_q        <= DEPOSITO;
            intentos_q    <= '0;
            tmo_q         <= '0;
            actualizado_q <= 1'b0;
            entregar_q    <= 1'b0;
            incorrecto_q  <= 1'b0;
            advertencia_q <= 1'b0;
            bloqueo_q     <= 1'b0;
            fondos_q      <= 1'b0;
            desborde_q    <= 1'b0;
            agotado_q     <= 1'b0;
        end else begin
            actualizado_q <= 1'b0;
            entregar_q    <= 1'b0;
            incorrecto_q  <= 1'b0;
            advertencia_q <= 1'b0;
            fondos_q      <= 1'b0;
            desborde_q    <= 1'b0;
            agotado_q     <= 1'b0;
            case (estado_q)
                ST_IDLE: begin
                    if (tarjeta_recibida) begin
                        balance_q <= balance_inicial;
                        tmo_q     <= '0;
                        estado_q  <= ST_RECIBIENDO_PIN;
                    end
                end
                ST_RECIBIENDO_PIN: begin
                    if (!tarjeta_recibida) begin
                        estado_q <= ST_IDLE;
                    end else if (digito_stb) begin
                        tmo_q <= '0;
                        if (pin_completo) estado_q <= ST_COMPARAR_PIN;
                    end else if (tmo_q == TMO_LIMITE) begin
                        estado_q  <= ST_IDLE;
                        agotado_q <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                ST_COMPARAR_PIN: begin
                    if (!tarjeta_recibida) begin
                        estado_q <= ST_IDLE;
                    end else if (pin_recibido == pin) begin
                        intentos_q <= '0;
                        tmo_q      <= '0;
                        estado_q   <= ST_ESPERA_MONTO;
                    end else if (intentos_d == INT_MAX) begin
                        intentos_q <= intentos_d;
                        bloqueo_q  <= 1'b1;
                        estado_q   <= ST_BLOQUEO;
                    end else begin
                        intentos_q    <= intentos_d;
                        incorrecto_q  <= 1'b1;
                        advertencia_q <= (intentos_d == INT_AVISO);
                        tmo_q         <= '0;
                        estado_q      <= ST_RECIBIENDO_PIN;
                    end
                end
                ST_ESPERA_MONTO: begin
                    if (!tarjeta_recibida) begin
                        estado_q <= ST_IDLE;
                    end else if (monto_stb) begin
                        monto_q  <= monto;
                        tipo_q   <= tipo_trans;
                        estado_q <= ST_TRANSACCION;
                    end else if (tmo_q == TMO_LIMITE) begin
                        estado_q  <= ST_IDLE;
                        agotado_q <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                ST_TRANSACCION: begin
                    estado_q <= ST_IDLE;
                    if (tipo_q == DEPOSITO) begin
                        if (suma[BAL_W]) begin
                            desborde_q <= 1'b1;
                        end else begin
                            balance_q     <= suma[BAL_W-1:0];
                            actualizado_q <= 1'b1;
                        end
                    end else if (monto_ext <= balance_q) begin
                        balance_q     <= balance_q - monto_ext;
                        actualizado_q <= 1'b1;
                        entregar_q    <= 1'b1;
                    end else begin
                        fondos_q <= 1'b1;
                    end
                end
                ST_BLOQUEO: begin
                    bloqueo_q <= 1'b1;
                end
                default: begin
                    estado_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign balance              = balance_q;
    assign balance_actualizado  = actualizado_q;
    assign entregar_dinero      = entregar_q;
    assign pin_incorrecto       = incorrecto_q;
    assign advertencia          = advertencia_q;
    assign bloqueo              = bloqueo_q;
    assign fondos_insuficientes = fondos_q;
    assign desborde             = desborde_q;
    assign tiempo_agotado       = agotado_q;

endmodule
`default_nettype wire

// File: doc/cajero_param.md
Name: cajero_param

Overview:
- Parametrised next-generation ATM transaction controller.
- Collects a PIN of configurable length one 4-bit digit per strobe and compares it with the stored PIN.
- Tracks failed attempts against a configurable limit, then performs a deposit or withdrawal on a registered balance.
- Sits between the card/keypad front end and the account datapath; adds card-removal abort, entry timeout, deposit overflow detection and a sticky lock.

Parameters:
- PIN_DIGITS, 4, number of 4-bit PIN digits (>=1)
- BAL_W, 64, balance width in bits
- MONTO_W, 32, amount width in bits (MONTO_W <= BAL_W)
- MAX_INTENTOS, 3, wrong PINs that cause lock (>=2)
- TIMEOUT_CYC, 1024, idle cycles allowed in RECIBIENDO_PIN / ESPERA_MONTO (>=2)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- tarjeta_recibida  in  1  card present (level)
- tipo_trans  in  1  0 = deposit, 1 = withdrawal; sampled with monto_stb
- digito_stb  in  1  digito valid this cycle
- digito  in  4  PIN digit
- pin  in  4*PIN_DIGITS  stored PIN; first digit in MS nibble
- balance_inicial  in  BAL_W  account balance, sampled on card acceptance
- monto  in  MONTO_W  amount, sampled with monto_stb
- monto_stb  in  1  amount/type valid this cycle
- balance  out  BAL_W  working balance register
- balance_actualizado  out  1  1-cycle pulse, balance changed
- entregar_dinero  out  1  1-cycle pulse, dispense (withdrawal ok)
- pin_incorrecto  out  1  1-cycle pulse, wrong PIN, not locked
- advertencia  out  1  1-cycle pulse, wrong PIN, exactly one attempt left
- bloqueo  out  1  sticky lock level
- fondos_insuficientes  out  1  1-cycle pulse, withdrawal > balance
- desborde  out  1  1-cycle pulse, deposit would overflow BAL_W
- tiempo_agotado  out  1  1-cycle pulse, entry timeout abort

Behaviour:
- All outputs registered. With reset low at a rising edge: all outputs 0, balance 0, state IDLE, attempt counter 0, digit counter 0, timeout counter 0. Reset mid-operation aborts everything, including BLOQUEO.
- States (one-hot): IDLE, RECIBIENDO_PIN, COMPARAR_PIN, ESPERA_MONTO, TRANSACCION, BLOQUEO.
- IDLE, tarjeta_recibida=1: load balance <= balance_inicial; clear digit counter; go to RECIBIENDO_PIN.
- RECIBIENDO_PIN: each digito_stb shifts digito into the LS nibble of pin_recibido (shift left by 4) and increments the digit counter. The strobe delivering digit PIN_DIGITS moves to COMPARAR_PIN on the same edge. Strobes in other states are ignored.
- COMPARAR_PIN (1 cycle):
  - Match: clear attempts, go to ESPERA_MONTO.
  - Mismatch: attempts+1. If the new count == MAX_INTENTOS: go to BLOQUEO, bloqueo=1. Otherwise pulse pin_incorrecto, additionally pulse advertencia if the new count == MAX_INTENTOS-1, clear the digit counter, return to RECIBIENDO_PIN.
- Attempt counter persists across card sessions and timeouts. Only a correct PIN or reset clears it.
- ESPERA_MONTO: on monto_stb, capture monto and tipo_trans, go to TRANSACCION.
- TRANSACCION (1 cycle), then IDLE:
  - Deposit: compute the BAL_W+1-bit sum. Carry=1: pulse desborde, balance unchanged. Otherwise update balance, pulse balance_actualizado.
  - Withdrawal: monto <= balance (monto zero-extended, equal allowed): subtract, pulse balance_actualizado and entregar_dinero in the same cycle. Otherwise pulse fondos_insuficientes.
- Pulses appear in the cycle after the deciding edge and last exactly one cycle. Latency: last digit strobe at edge N -> compare at N+1 -> pin_incorrecto visible after N+1; monto_stb at edge M -> balance and pulses visible after M+1.
- Timeout: counter clears on state entry and on any strobe accepted in that state, and increments otherwise. Reaching TIMEOUT_CYC-1 idle cycles -> IDLE with a tiempo_agotado pulse; attempts kept.
- tarjeta_recibida=0 in RECIBIENDO_PIN, COMPARAR_PIN or ESPERA_MONTO -> IDLE, no pulse, balance held.
- Card removal has priority over strobes and timeout in the same cycle. Card removal during TRANSACCION does not cancel it.
- BLOQUEO: absorbing. bloqueo=1 and all inputs are ignored until reset.
- Unreachable encodings -> IDLE.

Decomposition:
- Package cajero_pkg: state one-hot localparams, DEPOSITO=1'b0, RETIRO=1'b1.
- Sub-module cajero_pin_colector: PIN shift register, digit counter and `completo` flag, with PIN_DIGITS as its only parameter and a clear input.
- The FSM, timeout counter and balance datapath stay in cajero_param.

Test Plan:
- pin=16'h1234, digits 1,2,3,4, deposit 500 on balance_inicial 1000 -> balance=1500, one balance_actualizado pulse, return to IDLE.
- Correct PIN, withdraw 1000 from 1000 -> balance=0, balance_actualizado and entregar_dinero same cycle; then withdraw 1 from 0 -> fondos_insuficientes only, balance 0.
- MAX_INTENTOS=3, three wrong PINs 0000 -> pin_incorrecto pulse; pin_incorrecto+advertencia; then bloqueo=1 sticky. Digits and card ignored until reset low one cycle -> all outputs 0.
- Two wrong PINs, correct third -> no lock; counter cleared, so a later wrong PIN gives pin_incorrecto without advertencia.
- BAL_W=8, balance_inicial=250, deposit 10 -> desborde pulse, balance 250; TIMEOUT_CYC=16, no digit for 15 cycles -> tiempo_agotado, IDLE.
- Card removed after 2 digits -> IDLE, no pulses; reinsert and full correct PIN still accepted (digit counter restarted).
